// File: rtl/eth_idma_req_arbiter.sv
// Round-robin arbiter sharing one Ethernet iDMA backend between TX (0) and RX (1),
// with an in-order route FIFO steering backend responses back to their issuer.
package eth_idma_pkg;
  typedef struct packed {
    logic [31:0] length;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } idma_req_t;

  typedef struct packed {
    logic [3:0] cause;
    logic       error;
  } idma_rsp_t;
endpackage

module eth_idma_req_arbiter #(
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [$bits(eth_idma_pkg::idma_req_t)-1:0] tx_req_i,
  input  logic                                      tx_req_valid_i,
  output logic                                      tx_req_ready_o,
  output logic [$bits(eth_idma_pkg::idma_rsp_t)-1:0] tx_rsp_o,
  output logic                                      tx_rsp_valid_o,
  input  logic                                      tx_rsp_ready_i,
  input  logic [$bits(eth_idma_pkg::idma_req_t)-1:0] rx_req_i,
  input  logic                                      rx_req_valid_i,
  output logic                                      rx_req_ready_o,
  output logic [$bits(eth_idma_pkg::idma_rsp_t)-1:0] rx_rsp_o,
  output logic                                      rx_rsp_valid_o,
  input  logic                                      rx_rsp_ready_i,
  output logic [$bits(eth_idma_pkg::idma_req_t)-1:0] be_req_o,
  output logic                                      be_req_valid_o,
  input  logic                                      be_req_ready_i,
  input  logic [$bits(eth_idma_pkg::idma_rsp_t)-1:0] be_rsp_i,
  input  logic                                      be_rsp_valid_i,
  output logic                                      be_rsp_ready_o,
  output logic [CntWidth-1:0]                       outstanding_o,
  output logic                                      busy_o
);
  import eth_idma_pkg::*;

  localparam int unsigned PtrW = $clog2(MaxOutstanding);

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic idx;
    logic is_local;
  } route_t;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             lock_q, lock_d;
  route_t           fifo_q [MaxOutstanding];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntWidth-1:0] cnt_q;

  logic             full, empty, push, pop;
  route_t           push_data, head;
  logic             gnt, gnt_idx;
  idma_req_t        gnt_req;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;

  assign req_valid = {rx_req_valid_i, tx_req_valid_i};
  assign rsp_ready = {rx_rsp_ready_i, tx_rsp_ready_i};
  assign full      = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty     = (cnt_q == '0);
  assign head      = fifo_q[rptr_q];

  assign tx_req_ready_o = req_ready[0];
  assign rx_req_ready_o = req_ready[1];
  assign tx_rsp_valid_o = rsp_valid[0];
  assign rx_rsp_valid_o = rsp_valid[1];
  assign outstanding_o  = cnt_q;
  assign busy_o         = (cnt_q != '0) | tx_req_valid_i | rx_req_valid_i;

  // A LOCKED grant owns a FIFO slot reserved when it was first granted, so full only gates IDLE.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    lock_d         = lock_q;
    gnt            = 1'b0;
    gnt_idx        = rr_q;
    req_ready      = '0;
    be_req_valid_o = 1'b0;
    be_req_o       = '0;
    push           = 1'b0;
    push_data      = '0;

    if (rst_ni) begin
      if (state_q == LOCKED) begin
        gnt     = 1'b1;
        gnt_idx = lock_q;
      end else if (!full && (|req_valid)) begin
        gnt     = 1'b1;
        gnt_idx = req_valid[rr_q] ? rr_q : ~rr_q;
      end
    end

    gnt_req = gnt_idx ? rx_req_i : tx_req_i;

    if (gnt) begin
      if (gnt_req.length == '0) begin
        req_ready[gnt_idx] = 1'b1;
        push               = 1'b1;
        push_data          = '{idx: gnt_idx, is_local: 1'b1};
      end else begin
        be_req_valid_o     = 1'b1;
        be_req_o           = gnt_req;
        req_ready[gnt_idx] = be_req_ready_i;
        push               = be_req_ready_i;
        push_data          = '{idx: gnt_idx, is_local: 1'b0};
        if (!be_req_ready_i) begin
          state_d = LOCKED;
          lock_d  = gnt_idx;
        end
      end
      if (push) begin
        rr_d    = ~gnt_idx;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    be_rsp_ready_o = 1'b0;
    rsp_valid      = '0;
    tx_rsp_o       = '0;
    rx_rsp_o       = '0;
    pop            = 1'b0;

    if (rst_ni && !empty) begin
      if (head.is_local) begin
        rsp_valid[head.idx] = 1'b1;
        pop                 = rsp_ready[head.idx];
      end else begin
        be_rsp_ready_o      = rsp_ready[head.idx];
        rsp_valid[head.idx] = be_rsp_valid_i;
        pop                 = be_rsp_valid_i & rsp_ready[head.idx];
        if (head.idx) rx_rsp_o = be_rsp_i;
        else          tx_rsp_o = be_rsp_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      lock_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) fifo_q[wptr_q] <= push_data;
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (be_req_valid_o && !be_req_ready_i) |=> $stable(be_req_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(be_rsp_valid_i && empty));

endmodule

// File: tb/tb_eth_idma_req_arbiter.sv
// Directed cycle-by-cycle vectors for the iDMA request arbiter, plus hand-written
// sequences for FIFO-full back-pressure and reset while a grant is locked.
module tb_eth_idma_req_arbiter;
  import eth_idma_pkg::*;

  localparam int RW = $bits(idma_req_t);
  localparam int SW = $bits(idma_rsp_t);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] tx_req, rx_req, be_req;
  logic          tx_req_valid, tx_req_ready, rx_req_valid, rx_req_ready;
  logic [SW-1:0] tx_rsp, rx_rsp, be_rsp;
  logic          tx_rsp_valid, tx_rsp_ready, rx_rsp_valid, rx_rsp_ready;
  logic          be_req_valid, be_req_ready, be_rsp_valid, be_rsp_ready;
  logic [2:0]    outstanding;
  logic          busy;

  int checks = 0;
  int errors = 0;

  eth_idma_req_arbiter #(.MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_req_i(tx_req), .tx_req_valid_i(tx_req_valid), .tx_req_ready_o(tx_req_ready),
    .tx_rsp_o(tx_rsp), .tx_rsp_valid_o(tx_rsp_valid), .tx_rsp_ready_i(tx_rsp_ready),
    .rx_req_i(rx_req), .rx_req_valid_i(rx_req_valid), .rx_req_ready_o(rx_req_ready),
    .rx_rsp_o(rx_rsp), .rx_rsp_valid_o(rx_rsp_valid), .rx_rsp_ready_i(rx_rsp_ready),
    .be_req_o(be_req), .be_req_valid_o(be_req_valid), .be_req_ready_i(be_req_ready),
    .be_rsp_i(be_rsp), .be_rsp_valid_i(be_rsp_valid), .be_rsp_ready_o(be_rsp_ready),
    .outstanding_o(outstanding), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        tv;   logic [31:0] tl;
    logic        rv;   logic [31:0] rl;
    logic        brdy; logic bv; logic [4:0] brsp;
    logic        trr;  logic rrr;
    logic        e_tr; logic e_rr;
    logic [1:0]  e_bsel; logic [31:0] e_blen;  // 0 none, 1 TX payload, 2 RX payload
    logic        e_brr;
    logic        e_tv; logic [4:0] e_trsp;
    logic        e_rv; logic [4:0] e_rrsp;
    logic [2:0]  e_out;
  } vec_t;

  vec_t vq[$];

  function automatic logic [RW-1:0] mkreq(input logic [31:0] len, input logic [31:0] src,
                                           input logic [31:0] dst);
    idma_req_t r;
    r.length = len; r.src_addr = src; r.dst_addr = dst;
    return r;
  endfunction

  function automatic vec_t mk(input string n,
      input logic tv, input logic [31:0] tl, input logic rv, input logic [31:0] rl,
      input logic brdy, input logic bv, input logic [4:0] brsp, input logic trr, input logic rrr,
      input logic e_tr, input logic e_rr, input logic [1:0] e_bsel, input logic [31:0] e_blen,
      input logic e_brr, input logic e_tv, input logic [4:0] e_trsp,
      input logic e_rv, input logic [4:0] e_rrsp, input logic [2:0] e_out);
    vec_t v;
    v.name = n; v.tv = tv; v.tl = tl; v.rv = rv; v.rl = rl;
    v.brdy = brdy; v.bv = bv; v.brsp = brsp; v.trr = trr; v.rrr = rrr;
    v.e_tr = e_tr; v.e_rr = e_rr; v.e_bsel = e_bsel; v.e_blen = e_blen; v.e_brr = e_brr;
    v.e_tv = e_tv; v.e_trsp = e_trsp; v.e_rv = e_rv; v.e_rrsp = e_rrsp; v.e_out = e_out;
    return v;
  endfunction

  task automatic chk(input string n, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic [31:0] tl, input logic rv, input logic [31:0] rl,
                       input logic brdy, input logic bv, input logic [4:0] brsp,
                       input logic trr, input logic rrr);
    tx_req_valid = tv; tx_req = mkreq(tl, 32'h1000, 32'hA000);
    rx_req_valid = rv; rx_req = mkreq(rl, 32'h2000, 32'hB000);
    be_req_ready = brdy; be_rsp_valid = bv; be_rsp = brsp;
    tx_rsp_ready = trr; rx_rsp_ready = rrr;
  endtask

  task automatic run_vec(input vec_t v);
    logic [RW-1:0] exp_req;
    @(negedge clk);
    drive(v.tv, v.tl, v.rv, v.rl, v.brdy, v.bv, v.brsp, v.trr, v.rrr);
    #4;
    case (v.e_bsel)
      2'd1:    exp_req = mkreq(v.e_blen, 32'h1000, 32'hA000);
      2'd2:    exp_req = mkreq(v.e_blen, 32'h2000, 32'hB000);
      default: exp_req = '0;
    endcase
    chk({v.name, ".tx_ready"},     RW'(tx_req_ready), RW'(v.e_tr));
    chk({v.name, ".rx_ready"},     RW'(rx_req_ready), RW'(v.e_rr));
    chk({v.name, ".be_req_valid"}, RW'(be_req_valid), RW'(v.e_bsel != 2'd0));
    chk({v.name, ".be_req"},       be_req, exp_req);
    chk({v.name, ".be_rsp_ready"}, RW'(be_rsp_ready), RW'(v.e_brr));
    chk({v.name, ".tx_rsp_valid"}, RW'(tx_rsp_valid), RW'(v.e_tv));
    chk({v.name, ".tx_rsp"},       RW'(tx_rsp), RW'(v.e_trsp));
    chk({v.name, ".rx_rsp_valid"}, RW'(rx_rsp_valid), RW'(v.e_rv));
    chk({v.name, ".rx_rsp"},       RW'(rx_rsp), RW'(v.e_rrsp));
    chk({v.name, ".outstanding"},  RW'(outstanding), RW'(v.e_out));
  endtask

  initial begin
    //        name   tv tl   rv rl   brdy bv brsp   trr rrr  etr err bsel blen  brr  etv etrsp  erv errsp  out
    // both requesters streaming, responses two cycles behind
    vq.push_back(mk("a0", 1, 64, 1, 64, 1, 0, 5'h00, 1, 1,  1, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("a1", 1, 64, 1, 64, 1, 0, 5'h00, 1, 1,  0, 1, 2, 64,  1,  0, 5'h00, 0, 5'h00, 1));
    vq.push_back(mk("a2", 1, 64, 1, 64, 1, 1, 5'h02, 1, 1,  1, 0, 1, 64,  1,  1, 5'h02, 0, 5'h00, 2));
    vq.push_back(mk("a3", 1, 64, 1, 64, 1, 1, 5'h04, 1, 1,  0, 1, 2, 64,  1,  0, 5'h00, 1, 5'h04, 2));
    vq.push_back(mk("a4", 0, 0,  0, 0,  1, 1, 5'h06, 1, 1,  0, 0, 0, 0,   1,  1, 5'h06, 0, 5'h00, 2));
    vq.push_back(mk("a5", 0, 0,  0, 0,  1, 1, 5'h08, 1, 1,  0, 0, 0, 0,   1,  0, 5'h00, 1, 5'h08, 1));
    vq.push_back(mk("a6", 0, 0,  0, 0,  1, 0, 5'h00, 1, 1,  0, 0, 0, 0,   0,  0, 5'h00, 0, 5'h00, 0));
    // TX held off by backend for five cycles; RX arrives while locked
    vq.push_back(mk("b0", 1, 64, 0, 0,  0, 0, 5'h00, 1, 1,  0, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b1", 1, 64, 0, 0,  0, 0, 5'h00, 1, 1,  0, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b2", 1, 64, 1, 64, 0, 0, 5'h00, 1, 1,  0, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b3", 1, 64, 1, 64, 0, 0, 5'h00, 1, 1,  0, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b4", 1, 64, 1, 64, 0, 0, 5'h00, 1, 1,  0, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b5", 1, 64, 1, 64, 1, 0, 5'h00, 1, 1,  1, 0, 1, 64,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("b6", 0, 0,  1, 64, 1, 0, 5'h00, 1, 1,  0, 1, 2, 64,  1,  0, 5'h00, 0, 5'h00, 1));
    vq.push_back(mk("b7", 0, 0,  0, 0,  1, 1, 5'h0A, 1, 1,  0, 0, 0, 0,   1,  1, 5'h0A, 0, 5'h00, 2));
    vq.push_back(mk("b8", 0, 0,  0, 0,  1, 1, 5'h0C, 1, 1,  0, 0, 0, 0,   1,  0, 5'h00, 1, 5'h0C, 1));
    // zero-length RX completes locally, but only after the older TX response
    vq.push_back(mk("d0", 1, 128, 0, 0, 1, 0, 5'h00, 1, 1,  1, 0, 1, 128, 0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("d1", 0, 0,  1, 0,  1, 0, 5'h00, 1, 1,  0, 1, 0, 0,   1,  0, 5'h00, 0, 5'h00, 1));
    vq.push_back(mk("d2", 0, 0,  0, 0,  1, 0, 5'h00, 1, 1,  0, 0, 0, 0,   1,  0, 5'h00, 0, 5'h00, 2));
    vq.push_back(mk("d3", 0, 0,  0, 0,  1, 1, 5'h0E, 1, 1,  0, 0, 0, 0,   1,  1, 5'h0E, 0, 5'h00, 2));
    vq.push_back(mk("d4", 0, 0,  0, 0,  1, 0, 5'h00, 1, 1,  0, 0, 0, 0,   0,  0, 5'h00, 1, 5'h00, 1));
    vq.push_back(mk("d5", 0, 0,  0, 0,  1, 0, 5'h00, 1, 1,  0, 0, 0, 0,   0,  0, 5'h00, 0, 5'h00, 0));
    // RX error response back-pressured by the requester for three cycles
    vq.push_back(mk("e0", 0, 0,  1, 32, 1, 0, 5'h00, 1, 1,  0, 1, 2, 32,  0,  0, 5'h00, 0, 5'h00, 0));
    vq.push_back(mk("e1", 0, 0,  0, 0,  1, 1, 5'h13, 1, 0,  0, 0, 0, 0,   0,  0, 5'h00, 1, 5'h13, 1));
    vq.push_back(mk("e2", 0, 0,  0, 0,  1, 1, 5'h13, 1, 0,  0, 0, 0, 0,   0,  0, 5'h00, 1, 5'h13, 1));
    vq.push_back(mk("e3", 0, 0,  0, 0,  1, 1, 5'h13, 1, 0,  0, 0, 0, 0,   0,  0, 5'h00, 1, 5'h13, 1));
    vq.push_back(mk("e4", 0, 0,  0, 0,  1, 1, 5'h13, 1, 1,  0, 0, 0, 0,   1,  0, 5'h00, 1, 5'h13, 1));
    vq.push_back(mk("e5", 0, 0,  0, 0,  1, 0, 5'h00, 1, 1,  0, 0, 0, 0,   0,  0, 5'h00, 0, 5'h00, 0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 5'h00, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst.outstanding",  RW'(outstanding), RW'(0));
    chk("rst.busy",         RW'(busy), RW'(0));
    chk("rst.be_req_valid", RW'(be_req_valid), RW'(0));
    chk("rst.be_req",       be_req, RW'(0));
    chk("rst.be_rsp_ready", RW'(be_rsp_ready), RW'(0));

    foreach (vq[i]) run_vec(vq[i]);

    // fill the route FIFO with no backend responses
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 64, 1, 64, 1, 0, 5'h00, 1, 1);
      #4;
      chk($sformatf("full%0d.tx_ready", i), RW'(tx_req_ready), RW'(i % 2 == 0));
      chk($sformatf("full%0d.rx_ready", i), RW'(rx_req_ready), RW'(i % 2 == 1));
      chk($sformatf("full%0d.outstanding", i), RW'(outstanding), RW'(i));
    end
    @(negedge clk);
    #4;
    chk("full4.tx_ready",     RW'(tx_req_ready), RW'(0));
    chk("full4.rx_ready",     RW'(rx_req_ready), RW'(0));
    chk("full4.be_req_valid", RW'(be_req_valid), RW'(0));
    chk("full4.outstanding",  RW'(outstanding), RW'(4));
    @(negedge clk);
    drive(1, 64, 1, 64, 1, 1, 5'h02, 1, 1);
    #4;
    chk("pop.tx_ready",     RW'(tx_req_ready), RW'(0));
    chk("pop.tx_rsp_valid", RW'(tx_rsp_valid), RW'(1));
    chk("pop.be_rsp_ready", RW'(be_rsp_ready), RW'(1));
    @(negedge clk);
    drive(1, 64, 1, 64, 1, 0, 5'h00, 1, 1);
    #4;
    chk("after_pop.tx_ready",    RW'(tx_req_ready), RW'(1));
    chk("after_pop.rx_ready",    RW'(rx_req_ready), RW'(0));
    chk("after_pop.outstanding", RW'(outstanding), RW'(3));

    // drop to three outstanding, lock TX, then reset
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 5'h04, 1, 1);
    #4;
    chk("drain.rx_rsp_valid", RW'(rx_rsp_valid), RW'(1));
    chk("drain.outstanding",  RW'(outstanding), RW'(4));
    @(negedge clk);
    drive(1, 64, 0, 0, 0, 0, 5'h00, 1, 1);
    #4;
    chk("lock.be_req_valid", RW'(be_req_valid), RW'(1));
    chk("lock.tx_ready",     RW'(tx_req_ready), RW'(0));
    chk("lock.outstanding",  RW'(outstanding), RW'(3));
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    chk("in_rst.be_req_valid", RW'(be_req_valid), RW'(0));
    chk("in_rst.tx_ready",     RW'(tx_req_ready), RW'(0));
    chk("in_rst.busy",         RW'(busy), RW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5'h00, 1, 1);
    #4;
    chk("post_rst.outstanding",  RW'(outstanding), RW'(0));
    chk("post_rst.be_req_valid", RW'(be_req_valid), RW'(0));
    chk("post_rst.busy",         RW'(busy), RW'(0));
    chk("post_rst.rsp_valid",    RW'({tx_rsp_valid, rx_rsp_valid}), RW'(0));
    chk("post_rst.be_rsp_ready", RW'(be_rsp_ready), RW'(0));
    @(negedge clk);
    drive(1, 64, 1, 64, 1, 0, 5'h00, 1, 1);
    #4;
    chk("ptr_tx.tx_ready", RW'(tx_req_ready), RW'(1));
    chk("ptr_tx.rx_ready", RW'(rx_req_ready), RW'(0));
    chk("ptr_tx.be_req",   be_req, mkreq(64, 32'h1000, 32'hA000));
    chk("ptr_tx.busy",     RW'(busy), RW'(1));
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 5'h00, 1, 1);
    #4;
    chk("final.outstanding", RW'(outstanding), RW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
